fir_serial_mc: RTL and testbench
================================

FIR_SERIAL_MC -- requirements
Module: fir_serial_mc

Interface
REQ-001 SHALL have parameter NR_STAGES, default 32, number of taps (2..256).
REQ-002 SHALL have parameter DWIDTH, default 16, signed sample/coefficient width.
REQ-003 SHALL have parameter NR_CH, default 4, number of independent channels (1..16).
REQ-004 SHALL have parameter SHIFT, default 15, arithmetic right shift applied to accumulator before output.
REQ-005 SHALL have ports: clk input 1 clock; rst input 1 reset, synchronous, active-high.
REQ-006 SHALL have ports: req_in output 1 sample request; ack_in input 1 sample acknowledge; data_in input DWIDTH signed sample; ch_in input clog2(NR_CH) (min 1) channel of sample.
REQ-007 SHALL have ports: req_out output 1 result valid request; ack_out input 1 result acknowledge; data_out output DWIDTH signed result; ch_out output clog2(NR_CH) (min 1) channel of result; sat output 1 result was saturated.
REQ-008 SHALL have port h_in input NR_STAGES*DWIDTH coefficients shared by all channels, tap k at bits [k*DWIDTH +: DWIDTH], multiplying x[n-k].

Function
REQ-009 SHALL implement FSM IDLE, REQ, MAC, OUT, WAIT; IDLE->REQ when req_in, ack_in, req_out, ack_out all low.
REQ-010 SHALL assert req_in in REQ; on edge T with req_in && ack_in, capture data_in/ch_in, drop req_in, enter MAC.
REQ-011 SHALL keep a separate NR_STAGES-deep delay line per channel; capture shifts only channel ch_in (tap 0 = new sample, tap k = previous tap k-1, oldest discarded).
REQ-012 SHALL perform one multiply-accumulate per cycle in MAC, NR_STAGES cycles (T+1..T+NR_STAGES), accumulator cleared at capture.
REQ-013 SHALL use accumulator width 2*DWIDTH+clog2(NR_STAGES); no intermediate overflow.
REQ-014 SHALL form result = (acc + 2^(SHIFT-1)) >>> SHIFT (round half up; SHIFT=0 means no rounding), saturated to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1]; sat=1 iff clipped.
REQ-015 SHALL register data_out, ch_out, sat and raise req_out at edge T+NR_STAGES+1 (state OUT); outputs stable while req_out high.
REQ-016 SHALL drop req_out on the edge after ack_out sampled high, enter WAIT, and return to IDLE only when ack_out low (four-phase).
REQ-017 SHALL ignore ack_in outside REQ and ack_out outside OUT.
REQ-018 SHALL treat ch_in >= NR_CH as channel NR_CH-1.
REQ-019 SHALL sustain one sample per NR_STAGES+4 cycles minimum when ack partners respond in one cycle.

Reset
REQ-020 SHALL on rst: FSM IDLE, req_in=0, req_out=0, data_out=0, ch_out=0, sat=0, accumulator 0, all delay lines 0.
REQ-021 SHALL abort any transaction on rst in any state (incl. mid-MAC); the in-flight result is never presented and the next req_in rises at the earliest the second edge after rst deasserts.

Structure
REQ-022 SHALL place state encoding and width functions (clog2, accumulator width) in shared package fir_pkg.
REQ-023 SHALL implement multiply, accumulate, round and saturate in sub-module fir_mac; delay-line storage and FSM in fir_serial_mc.

Verification
REQ-024 Impulse: NR_CH=1, h_in taps 1..32 = 1000..1031, SHIFT=0, sample 1 then zeros -> outputs 1000,1001,...,1031 then 0, sat=0.
REQ-025 Latency: ack_in at edge T, ack_out held low -> req_out rises exactly at edge T+33 (NR_STAGES=32), holds data until ack_out.
REQ-026 Saturation: all taps 32767, SHIFT=15, 32 samples of 32767 -> data_out=32767, sat=1; all samples -32768 -> data_out=-32768, sat=1.
REQ-027 Channel isolation: NR_CH=4, impulse on ch 2, zeros on ch 0,1,3 interleaved -> only ch_out=2 results nonzero, matching REQ-024 sequence.
REQ-028 Back-pressure: ack_out delayed 50 cycles -> req_in stays low, no sample lost, data_out unchanged until ack_out.
REQ-029 Reset mid-MAC: rst at T+10 -> no req_out, all outputs 0, next impulse yields REQ-024 sequence from zeroed history.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the serial multi-channel FIR: controller state encoding
// and the elaboration-time width helpers used by the datapath and the controller.
package fir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_MAC  = 3'd2,
    ST_OUT  = 3'd3,
    ST_WAIT = 3'd4
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Channel fields stay at least one bit wide even for a single channel.
  function automatic int ch_width(input int nr_ch);
    return (clog2(nr_ch) < 1) ? 1 : clog2(nr_ch);
  endfunction

  // Wide enough to sum NR_STAGES full-scale products without wrapping.
  function automatic int acc_width(input int dwidth, input int nr_stages);
    return 2 * dwidth + clog2(nr_stages);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate datapath: one signed product per enabled cycle, plus the
// round-half-up shift and the clip to the output range.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int NR_STAGES = 32,
  parameter int SHIFT     = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_en,
  input  logic signed [DWIDTH-1:0] i_coef,
  input  logic signed [DWIDTH-1:0] i_sample,
  output logic signed [DWIDTH-1:0] o_result,
  output logic                     o_sat
);

  localparam int AW  = acc_width(DWIDTH, NR_STAGES);
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [AW:0] RND  = (SHIFT > 0) ? ((AW + 1)'(1) << RSH) : '0;
  localparam logic signed [AW:0] MAXV = (AW + 1)'((64'sd1 <<< (DWIDTH - 1)) - 64'sd1);
  localparam logic signed [AW:0] MINV = ~MAXV;

  logic signed [2*DWIDTH-1:0] w_prod;
  logic signed [AW-1:0]       w_prod_ext;
  logic signed [AW-1:0]       r_acc;
  logic signed [AW:0]         w_round;
  logic signed [AW:0]         w_shifted;

  assign w_prod     = i_coef * i_sample;
  assign w_prod_ext = {{(AW - 2 * DWIDTH){w_prod[2*DWIDTH-1]}}, w_prod};

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  // One guard bit keeps the rounding add from wrapping at the accumulator extremes.
  assign w_round   = {r_acc[AW-1], r_acc} + RND;
  assign w_shifted = w_round >>> SHIFT;

  always_comb begin
    o_result = w_shifted[DWIDTH-1:0];
    o_sat    = 1'b0;
    if (w_shifted > MAXV) begin
      o_result = {1'b0, {(DWIDTH - 1){1'b1}}};
      o_sat    = 1'b1;
    end else if (w_shifted < MINV) begin
      o_result = {1'b1, {(DWIDTH - 1){1'b0}}};
      o_sat    = 1'b1;
    end
  end

endmodule

// File: rtl/fir_serial_mc.sv
// Serial multi-channel FIR: per-channel delay lines, one MAC per cycle, and
// four-phase req/ack handshakes on both the sample and the result side.
module fir_serial_mc
  import fir_pkg::*;
#(
  parameter int NR_STAGES = 32,
  parameter int DWIDTH    = 16,
  parameter int NR_CH     = 4,
  parameter int SHIFT     = 15,
  localparam int CW       = ch_width(NR_CH)
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          req_in,
  input  logic                          ack_in,
  input  logic signed [DWIDTH-1:0]      data_in,
  input  logic [CW-1:0]                 ch_in,
  output logic                          req_out,
  input  logic                          ack_out,
  output logic signed [DWIDTH-1:0]      data_out,
  output logic [CW-1:0]                 ch_out,
  output logic                          sat,
  input  logic [NR_STAGES*DWIDTH-1:0]   h_in,
  output logic [2:0]                    o_dbg_state
);

  // Handshake: a sample moves on the edge where req_in and ack_in are both high,
  // a result on the edge where req_out and ack_out are both high; each side then
  // waits for its ack to fall before the next request (four-phase).

  localparam int CNTW = clog2(NR_STAGES + 1);
  localparam int IW   = (clog2(NR_STAGES) < 1) ? 1 : clog2(NR_STAGES);
  localparam logic [CNTW-1:0] LAST = CNTW'(NR_STAGES);

  state_t                   r_state;
  logic                     r_req_in;
  logic                     r_req_out;
  logic                     r_rst_hold;
  logic [CW-1:0]            r_ch;
  logic [CW-1:0]            r_ch_out;
  logic [CNTW-1:0]          r_cnt;
  logic signed [DWIDTH-1:0] r_data_out;
  logic                     r_sat;
  logic signed [DWIDTH-1:0] r_dly [NR_CH][NR_STAGES];

  logic                     w_cap;
  logic                     w_mac_en;
  logic [CW-1:0]            w_ch_in;
  logic [IW-1:0]            w_idx;
  logic signed [DWIDTH-1:0] w_sample;
  logic signed [DWIDTH-1:0] w_coef;
  logic signed [DWIDTH-1:0] w_result;
  logic                     w_sat;

  assign w_cap    = (r_state == ST_REQ) && r_req_in && ack_in;
  assign w_mac_en = (r_state == ST_MAC) && (r_cnt != LAST);
  assign w_ch_in  = ({1'b0, ch_in} >= (CW + 1)'(NR_CH)) ? CW'(NR_CH - 1) : ch_in;
  assign w_idx    = (r_cnt < LAST) ? r_cnt[IW-1:0] : '0;
  assign w_sample = r_dly[r_ch][w_idx];
  assign w_coef   = h_in[w_idx*DWIDTH +: DWIDTH];

  fir_mac #(
    .DWIDTH   (DWIDTH),
    .NR_STAGES(NR_STAGES),
    .SHIFT    (SHIFT)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_cap),
    .i_en    (w_mac_en),
    .i_coef  (w_coef),
    .i_sample(w_sample),
    .o_result(w_result),
    .o_sat   (w_sat)
  );

  // Only the addressed channel shifts; the others keep their history untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NR_CH; c++) begin
        for (int k = 0; k < NR_STAGES; k++) begin
          r_dly[c][k] <= '0;
        end
      end
    end else if (w_cap) begin
      for (int k = NR_STAGES - 1; k > 0; k--) begin
        r_dly[w_ch_in][k] <= r_dly[w_ch_in][k-1];
      end
      r_dly[w_ch_in][0] <= data_in;
    end
  end

  // Holds off the first request for one extra edge after reset is released.
  always_ff @(posedge clk) begin
    r_rst_hold <= rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_req_in   <= 1'b0;
      r_req_out  <= 1'b0;
      r_ch       <= '0;
      r_ch_out   <= '0;
      r_cnt      <= '0;
      r_data_out <= '0;
      r_sat      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!r_rst_hold && !r_req_in && !ack_in && !r_req_out && !ack_out) begin
            r_req_in <= 1'b1;
            r_state  <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_in) begin
            r_ch     <= w_ch_in;
            r_req_in <= 1'b0;
            r_cnt    <= '0;
            r_state  <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (r_cnt == LAST) begin
            r_data_out <= w_result;
            r_sat      <= w_sat;
            r_ch_out   <= r_ch;
            r_req_out  <= 1'b1;
            r_state    <= ST_OUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_OUT: begin
          if (ack_out) begin
            r_req_out <= 1'b0;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!ack_out) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_in      = r_req_in;
  assign req_out     = r_req_out;
  assign data_out    = r_data_out;
  assign ch_out      = r_ch_out;
  assign sat         = r_sat;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fir_serial_mc.sv
// Bench for fir_serial_mc: two instances (SHIFT=0/4 channels, SHIFT=15/3 channels)
// driven in lockstep, checked against a behavioural FIR reference through queues.
module tb_fir_serial_mc;
  import fir_pkg::*;

  localparam int NS      = 32;
  localparam int DW      = 16;
  localparam int SHIFT_A = 0;
  localparam int SHIFT_B = 15;

  logic clk;
  logic rst;
  logic ack_in;
  logic ack_out;
  logic signed [DW-1:0] data_in;
  logic [1:0] ch_in;
  logic [NS*DW-1:0] h_in;

  logic req_in_a, req_out_a, sat_a;
  logic signed [DW-1:0] data_out_a;
  logic [1:0] ch_out_a;
  logic [2:0] dbg_a;
  logic req_in_b, req_out_b, sat_b;
  logic signed [DW-1:0] data_out_b;
  logic [1:0] ch_out_b;
  logic [2:0] dbg_b;

  fir_serial_mc #(.NR_STAGES(NS), .DWIDTH(DW), .NR_CH(4), .SHIFT(SHIFT_A)) dut_a (
    .clk(clk), .rst(rst), .req_in(req_in_a), .ack_in(ack_in), .data_in(data_in),
    .ch_in(ch_in), .req_out(req_out_a), .ack_out(ack_out), .data_out(data_out_a),
    .ch_out(ch_out_a), .sat(sat_a), .h_in(h_in), .o_dbg_state(dbg_a)
  );

  fir_serial_mc #(.NR_STAGES(NS), .DWIDTH(DW), .NR_CH(3), .SHIFT(SHIFT_B)) dut_b (
    .clk(clk), .rst(rst), .req_in(req_in_b), .ack_in(ack_in), .data_in(data_in),
    .ch_in(ch_in), .req_out(req_out_b), .ack_out(ack_out), .data_out(data_out_b),
    .ch_out(ch_out_b), .sat(sat_b), .h_in(h_in), .o_dbg_state(dbg_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic signed [DW-1:0] hc [NS];
  logic signed [DW-1:0] xa [4][NS];
  logic signed [DW-1:0] xb [3][NS];

  always_comb begin
    h_in = '0;
    for (int k = 0; k < NS; k++) h_in[k*DW +: DW] = hc[k];
  end

  function automatic void clear_models();
    for (int c = 0; c < 4; c++) for (int k = 0; k < NS; k++) xa[c][k] = '0;
    for (int c = 0; c < 3; c++) for (int k = 0; k < NS; k++) xb[c][k] = '0;
  endfunction

  function automatic logic [18:0] fir_ref(input longint acc, input int shift, input int c);
    longint r;
    logic s;
    logic [15:0] v;
    r = (shift > 0) ? ((acc + (longint'(1) <<< (shift - 1))) >>> shift) : acc;
    s = 1'b0;
    if (r > 32767) begin r = 32767; s = 1'b1; end
    else if (r < -32768) begin r = -32768; s = 1'b1; end
    v = 16'(r);
    return {s, 2'(c), v};
  endfunction

  function automatic logic [18:0] model_a(input logic signed [DW-1:0] d, input logic [1:0] ch);
    int c;
    longint acc;
    c = int'(ch);
    for (int k = NS - 1; k > 0; k--) xa[c][k] = xa[c][k-1];
    xa[c][0] = d;
    acc = 0;
    for (int k = 0; k < NS; k++) acc += longint'(hc[k]) * longint'(xa[c][k]);
    return fir_ref(acc, SHIFT_A, c);
  endfunction

  function automatic logic [18:0] model_b(input logic signed [DW-1:0] d, input logic [1:0] ch);
    int c;
    longint acc;
    c = (int'(ch) >= 3) ? 2 : int'(ch);
    for (int k = NS - 1; k > 0; k--) xb[c][k] = xb[c][k-1];
    xb[c][0] = d;
    acc = 0;
    for (int k = 0; k < NS; k++) acc += longint'(hc[k]) * longint'(xb[c][k]);
    return fir_ref(acc, SHIFT_B, c);
  endfunction

  // ---------------- scoreboard ----------------
  logic [18:0] exp_a_q[$];
  logic [18:0] exp_b_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic transact(input logic signed [DW-1:0] d, input logic [1:0] ch,
                          input int ack_delay, input bit spurious,
                          input bit use_tab, input logic signed [DW-1:0] tab_exp);
    int n;
    int cnt;
    bit stable;
    logic [18:0] got_a, got_b, e_a, e_b;
    if (use_tab) begin
      void'(model_a(d, ch));
      exp_a_q.push_back({1'b0, ch, tab_exp});
    end else begin
      exp_a_q.push_back(model_a(d, ch));
    end
    exp_b_q.push_back(model_b(d, ch));

    n = 0;
    while (!req_in_a && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      chk("req_in_timeout", n, 0);
      void'(exp_a_q.pop_front());
      void'(exp_b_q.pop_front());
      return;
    end
    data_in = d;
    ch_in   = ch;
    ack_in  = 1'b1;
    @(negedge clk);
    chk("req_in_drop", req_in_a, 0);
    ack_in = 1'b0;

    cnt = 1;
    while (!req_out_a && cnt < 200) begin
      ack_in  = spurious && cnt >= 3 && cnt < 6;
      ack_out = spurious && cnt >= 3 && cnt < 6;
      @(negedge clk);
      cnt++;
    end
    ack_in  = 1'b0;
    ack_out = 1'b0;
    chk("latency", cnt, NS + 2);
    chk("req_out_b", req_out_b, 1);

    got_a = {sat_a, ch_out_a, data_out_a};
    got_b = {sat_b, ch_out_b, data_out_b};
    e_a = exp_a_q.pop_front();
    e_b = exp_b_q.pop_front();
    chk("result_a", got_a, e_a);
    chk("result_b", got_b, e_b);

    if (ack_delay > 0) begin
      stable = 1'b1;
      repeat (ack_delay) begin
        @(negedge clk);
        if (!req_out_a || req_in_a || {sat_a, ch_out_a, data_out_a} !== got_a ||
            {sat_b, ch_out_b, data_out_b} !== got_b) stable = 1'b0;
      end
      chk("hold_outputs", stable, 1);
    end

    ack_out = 1'b1;
    @(negedge clk);
    chk("req_out_drop", req_out_a, 0);
    ack_out = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic signed [DW-1:0] d;
    logic [1:0]           ch;
    logic signed [DW-1:0] exp_a;
  } vec_t;

  vec_t vt [66];

  initial begin
    int n;
    bit quiet;
    rst     = 1'b1;
    ack_in  = 1'b0;
    ack_out = 1'b0;
    data_in = '0;
    ch_in   = '0;
    for (int k = 0; k < NS; k++) hc[k] = 16'(1000 + k);
    clear_models();

    // Impulse on channel 2 interleaved with silence on 0, 1 and 3.
    for (int i = 0; i < 33; i++) begin
      vt[2*i].d      = (i == 0) ? 16'sd1 : 16'sd0;
      vt[2*i].ch     = 2'd2;
      vt[2*i].exp_a  = (i < NS) ? 16'(1000 + i) : 16'sd0;
      vt[2*i+1].d    = 16'sd0;
      vt[2*i+1].ch   = (i % 3 == 0) ? 2'd0 : ((i % 3 == 1) ? 2'd1 : 2'd3);
      vt[2*i+1].exp_a = 16'sd0;
    end

    repeat (3) @(negedge clk);
    chk("rst_req_in", req_in_a, 0);
    chk("rst_req_out", req_out_a, 0);
    chk("rst_data_out", data_out_a, 0);
    chk("rst_ch_out", ch_out_a, 0);
    chk("rst_sat", sat_a, 0);
    chk("rst_state", dbg_a, int'(ST_IDLE));
    chk("rst_b_out", {req_in_b, req_out_b, sat_b, ch_out_b, data_out_b}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_recovery_req_in", req_in_a, 0);

    for (int i = 0; i < 66; i++) transact(vt[i].d, vt[i].ch, 0, 1'b0, 1'b1, vt[i].exp_a);

    // Random coefficients and samples, with one long back-pressure hold and one
    // burst of out-of-state acks.
    for (int k = 0; k < NS; k++) hc[k] = 16'($urandom_range(0, 8000)) - 16'd4000;
    for (int i = 0; i < 24; i++) begin
      logic signed [DW-1:0] d;
      d = (i % 2 == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 100)) - 16'd50;
      transact(d, 2'($urandom_range(0, 3)), (i == 10) ? 50 : int'($urandom_range(0, 3)),
               (i == 5), 1'b0, 16'sd0);
    end

    // Full-scale saturation in both directions on channel 1.
    for (int k = 0; k < NS; k++) hc[k] = 16'sd32767;
    for (int i = 0; i < NS; i++) transact(16'sd32767, 2'd1, 0, 1'b0, 1'b0, 16'sd0);
    chk("sat_pos_data_b", data_out_b, 32767);
    chk("sat_pos_flag_b", sat_b, 1);
    for (int i = 0; i < NS; i++) transact(-16'sd32768, 2'd1, 0, 1'b0, 1'b0, 16'sd0);
    chk("sat_neg_data_b", data_out_b, -32768);
    chk("sat_neg_flag_b", sat_b, 1);

    // Reset ten edges into the MAC phase.
    for (int k = 0; k < NS; k++) hc[k] = 16'(1000 + k);
    n = 0;
    while (!req_in_a && n < 100) begin @(negedge clk); n++; end
    chk("pre_reset_req_in", req_in_a, 1);
    data_in = 16'sd20000;
    ch_in   = 2'd0;
    ack_in  = 1'b1;
    @(negedge clk);
    ack_in = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_models();
    chk("mid_rst_req_out", req_out_a, 0);
    chk("mid_rst_data_out", data_out_a, 0);
    chk("mid_rst_ch_out", ch_out_a, 0);
    chk("mid_rst_sat", sat_a, 0);
    chk("mid_rst_b_out", {sat_b, ch_out_b, data_out_b}, 0);
    chk("mid_rst_state", dbg_a, int'(ST_IDLE));
    @(negedge clk);
    chk("mid_rst_recovery_req_in", req_in_a, 0);
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (req_out_a || req_out_b) quiet = 1'b0;
    end
    chk("mid_rst_no_result", quiet, 1);

    for (int i = 0; i < 33; i++)
      transact((i == 0) ? 16'sd1 : 16'sd0, 2'd0, 0, 1'b0, 1'b1,
               (i < NS) ? 16'(1000 + i) : 16'sd0);

    chk("queue_a_empty", exp_a_q.size(), 0);
    chk("queue_b_empty", exp_b_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
